// File: rtl/pixel_frame_streamer.sv
// Single-frame grayscale buffer with a raster-scan valid/ready read engine.
// Optional BINARIZE_EN thresholds the streamed pixel against THRESHOLD.
module pixel_frame_streamer #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned IMG_W     = 128,
  parameter int unsigned IMG_H     = 128,
  parameter string       INIT_FILE = "test_image1.hex",
  parameter int unsigned THRESHOLD = 128,
  localparam int unsigned DEPTH  = IMG_W * IMG_H,
  localparam int unsigned ADDR_W = $clog2(DEPTH),
  localparam int unsigned X_W    = $clog2(IMG_W),
  localparam int unsigned Y_W    = $clog2(IMG_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pixel,
  output logic [X_W-1:0]    out_x,
  output logic [Y_W-1:0]    out_y,
  output logic              out_sof,
  output logic              out_eol,
  output logic              out_eof,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_q;
  logic [ADDR_W-1:0] pix_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [X_W-1:0]    x;
  logic [Y_W-1:0]    y;
  logic              rd_en;
  logic              start_acc;
  logic              advance;
  logic              x_last;
  logic              last;
  logic              wr_ok;

  assign x_last    = (x == X_W'(IMG_W - 1));
  assign last      = x_last && (y == Y_W'(IMG_H - 1));
  assign start_acc = (state == S_IDLE) && start && !abort;
  assign advance   = (state == S_STREAM) && out_ready && !abort && !last;
  assign rd_en     = start_acc || advance;
  assign rd_addr   = start_acc ? '0 : pix_addr + ADDR_W'(1);
  assign wr_ok     = wr_en && (32'(wr_addr) < DEPTH);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (start && !abort) state_nxt = S_STREAM;
      S_STREAM: begin
        if (abort)                  state_nxt = S_IDLE;
        else if (out_ready && last) state_nxt = S_DONE;
      end
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_STREAM: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      S_DONE:   done = 1'b1;
      default:  ;
    endcase
  end

  // Counters track the beat on the output; the linear address runs alongside
  // so the next read needs no multiply.
  always_ff @(posedge clk) begin
    if (rst) begin
      x        <= '0;
      y        <= '0;
      pix_addr <= '0;
    end else if (start_acc) begin
      x        <= '0;
      y        <= '0;
      pix_addr <= '0;
    end else if (advance) begin
      pix_addr <= pix_addr + ADDR_W'(1);
      if (x_last) begin
        x <= '0;
        y <= y + Y_W'(1);
      end else begin
        x <= x + X_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
  end

  // Read register holds during stalls, keeping the presented pixel stable.
  always_ff @(posedge clk) begin
    if (rst)        rd_q <= '0;
    else if (rd_en) rd_q <= mem[rd_addr];
  end

  assign out_x = x;
  assign out_y = y;

`ifdef BINARIZE_EN
  assign out_pixel = (out_valid && (32'(rd_q) >= THRESHOLD)) ? '1 : '0;
`else
  assign out_pixel = rd_q;
`endif

  always_comb begin
    out_sof = out_valid && (x == '0) && (y == '0);
    out_eol = out_valid && x_last;
    out_eof = out_valid && last;
  end

endmodule

// File: tb/tb_pixel_frame_streamer.sv
// Scoreboard bench for pixel_frame_streamer on a 4x3 frame preloaded by host writes.
module tb_pixel_frame_streamer;

  localparam int W   = 4;
  localparam int H   = 3;
  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int XW  = 2;
  localparam int YW  = 2;
  localparam int THR = 6;

  logic          clk = 1'b0;
  logic          rst, start, abort, out_ready, wr_en;
  logic          busy, done, out_valid, out_sof, out_eol, out_eof;
  logic [DW-1:0] out_pixel, wr_data;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;
  logic [AW-1:0] wr_addr;

  typedef struct packed {
    logic [DW-1:0] pix;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          sof;
    logic          eol;
    logic          eof;
  } beat_t;

  beat_t         sb[$];
  logic [DW-1:0] model [W*H];
  int            n_cmp = 0;
  int            n_fail = 0;
  int            n;

  pixel_frame_streamer #(
    .DATA_W(DW), .IMG_W(W), .IMG_H(H), .INIT_FILE(""), .THRESHOLD(THR)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
    .out_pixel(out_pixel), .out_x(out_x), .out_y(out_y),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] view(input logic [DW-1:0] v);
`ifdef BINARIZE_EN
    return (v >= DW'(THR)) ? 8'hFF : 8'h00;
`else
    return v;
`endif
  endfunction

  function automatic beat_t exp_beat(input int i);
    beat_t b;
    b.pix = view(model[i]);
    b.x   = XW'(i % W);
    b.y   = YW'(i / W);
    b.sof = (i == 0);
    b.eol = ((i % W) == W - 1);
    b.eof = (i == W * H - 1);
    return b;
  endfunction

  task automatic push_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) sb.push_back(exp_beat(i));
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_scan;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (done !== 1'b1 && cnt < 60) begin
      tick;
      cnt++;
    end
    if (done !== 1'b1) check("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  32'(busy),      32'd0);
    check({tag, "_done"},  32'(done),      32'd0);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_pixel"}, 32'(out_pixel), 32'd0);
    check({tag, "_x"},     32'(out_x),     32'd0);
    check({tag, "_y"},     32'(out_y),     32'd0);
    check({tag, "_sof"},   32'(out_sof),   32'd0);
    check({tag, "_eol"},   32'(out_eol),   32'd0);
    check({tag, "_eof"},   32'(out_eof),   32'd0);
  endtask

  // Monitor: pops one expected beat per handshake and checks stall stability.
  beat_t held;
  logic  stall_prev = 1'b0;
  always @(negedge clk) begin
    beat_t cur;
    cur = '{out_pixel, out_x, out_y, out_sof, out_eol, out_eof};
    if (stall_prev && out_valid === 1'b1) check("stall_hold", 32'(cur), 32'(held));
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_beat: got %0h expected none (t=%0t)", cur, $time);
      end else begin
        check("beat", 32'(cur), 32'(sb.pop_front()));
      end
    end
    stall_prev = (out_valid === 1'b1) && (out_ready === 1'b0);
    held = cur;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;

    // Preload through the host port while reset is held.
    for (int i = 0; i < W * H; i++) begin
      model[i] = DW'(i);
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = DW'(i);
      tick;
    end
    wr_en = 1'b0;
    check_all_zero("reset");
    rst = 1'b0;
    tick;

    // Full scan under continuous ready.
    out_ready = 1'b1;
    push_range(0, 11);
    start_scan;
    check("first_valid", 32'(out_valid), 32'd1);
    check("first_busy",  32'(busy),      32'd1);
    wait_done(n);
    check("scan_cycles", 32'(n), 32'd12);
    check("done_busy",   32'(busy),      32'd0);
    check("done_valid",  32'(out_valid), 32'd0);
    tick;
    check("done_len",    32'(done), 32'd0);
    check("scan_sb_empty", 32'(sb.size()), 32'd0);

    // Backpressure on beat 5.
    push_range(0, 11);
    start_scan;
    repeat (5) tick;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("bp_pixel", 32'(out_pixel), 32'(view(model[5])));
      check("bp_x",     32'(out_x),     32'd1);
      check("bp_y",     32'(out_y),     32'd1);
      tick;
    end
    out_ready = 1'b1;
    wait_done(n);
    check("bp_cycles", 32'(n), 32'd7);
    tick;
    check("bp_sb_empty", 32'(sb.size()), 32'd0);

    // Abort while beat 6 is stalled, then restart.
    push_range(0, 5);
    start_scan;
    repeat (6) tick;
    out_ready = 1'b0;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_busy",  32'(busy),      32'd0);
    for (int k = 0; k < 3; k++) begin
      check("abort_no_done", 32'(done), 32'd0);
      tick;
    end
    check("abort_sb_empty", 32'(sb.size()), 32'd0);
    out_ready = 1'b1;
    start = 1'b1; abort = 1'b1;
    tick;
    start = 1'b0; abort = 1'b0;
    check("start_abort_valid", 32'(out_valid), 32'd0);
    check("start_abort_busy",  32'(busy),      32'd0);
    push_range(0, 11);
    start_scan;
    wait_done(n);
    check("restart_cycles", 32'(n), 32'd12);
    tick;

    // Host writes during a scan: in-range lands in beat 10, out-of-range ignored.
    model[10] = 8'hAA;
    push_range(0, 11);
    start_scan;
    repeat (2) tick;
    wr_en = 1'b1; wr_addr = AW'(10); wr_data = 8'hAA;
    tick;
    wr_addr = AW'(12); wr_data = 8'h55;
    tick;
    wr_en = 1'b0;
    wait_done(n);
    check("hw_cycles", 32'(n), 32'd8);
    tick;
    push_range(0, 11);
    start_scan;
    wait_done(n);
    tick;
    check("hw_sb_empty", 32'(sb.size()), 32'd0);
    model[10] = 8'd10;
    wr_en = 1'b1; wr_addr = AW'(10); wr_data = 8'd10;
    tick;
    wr_en = 1'b0;

    // Reset during beat 4 (which handshakes that cycle), then ignored starts.
    push_range(0, 4);
    start_scan;
    repeat (4) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check_all_zero("midrst");
    push_range(0, 11);
    start_scan;
    repeat (3) tick;
    start = 1'b1;
    tick;
    start = 1'b0;
    wait_done(n);
    check("busy_start_cycles", 32'(n), 32'd8);
    start = 1'b1;
    tick;
    start = 1'b0;
    check("done_start_valid", 32'(out_valid), 32'd0);
    check("done_start_busy",  32'(busy),      32'd0);
    repeat (2) tick;
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    repeat (2) tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
